refresh_sched: RTL

//  DRAM refresh scheduler for the TOM misc/memory-control area. It turns the 4-bit refrate

---
 rtl/tom_defs.sv | 21 ++
 rtl/ref_tick_gen.sv | 51 +++++
 rtl/refresh_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tom_defs.sv
// ============================================================================
// Package : tom_defs
// Shared refresh-scheduler encodings and field widths.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tom_defs;

    localparam int REFRATE_W = 4;
    localparam int OWE_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } ref_state_e;

endpackage : tom_defs

`default_nettype wire

// File: rtl/ref_tick_gen.sv
// ============================================================================
// Module : ref_tick_gen
// Prescaler plus interval counter; emits a one-cycle due pulse per interval.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_tick_gen
    import tom_defs::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic                 clk,
    input  logic                 resetl,
    input  logic [REFRATE_W-1:0] refrate,
    input  logic                 tcount,
    output logic                 due
);

    localparam logic [REFRATE_W-1:0] c_rate_one  = REFRATE_W'(1);
    localparam logic [PRESC_W-1:0]   c_presc_one = PRESC_W'(1);

    logic [PRESC_W-1:0]   r_presc;
    logic [REFRATE_W-1:0] r_icnt;
    logic                 w_tick;
    logic                 w_rate_on;
    logic                 w_wrap;

    assign w_tick    = tcount | (&r_presc);
    assign w_rate_on = |refrate;
    // ">=" rather than "==" so lowering refrate below the current count fires on the next tick
    assign w_wrap    = (r_icnt >= (refrate - c_rate_one));
    assign due       = w_tick & w_rate_on & w_wrap;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_presc <= '0;
            r_icnt  <= '0;
        end else begin
            r_presc <= r_presc + c_presc_one;
            if (!w_rate_on) begin
                r_icnt <= '0;
            end else if (w_tick) begin
                r_icnt <= w_wrap ? '0 : (r_icnt + c_rate_one);
            end
        end
    end

endmodule : ref_tick_gen

`default_nettype wire

// File: rtl/refresh_sched.sv
// ============================================================================
// Module : refresh_sched
// DRAM refresh scheduler: owed-refresh backlog and refreq/ack/refback handshake.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module refresh_sched
    import tom_defs::*;
#(
    parameter int PRESC_W   = 6,
    parameter int MAX_OWE   = 7,
    parameter int URGENT_TH = 4
) (
    input  logic                 clk,
    input  logic                 resetl,
    input  logic [REFRATE_W-1:0] refrate,
    input  logic                 tcount,
    input  logic                 startref,
    input  logic                 ack,
    input  logic                 refback,
    input  logic                 ovfclr,
    output logic                 refreq,
    output logic                 urgent,
    output logic [OWE_W-1:0]     owed,
    output logic                 ovf
);

    // One extra bit holds owed + 2 before saturation
    localparam int                 SUM_W   = OWE_W + 1;
    localparam logic [SUM_W-1:0]   c_max   = SUM_W'(MAX_OWE);
    localparam logic [SUM_W-1:0]   c_urg   = SUM_W'(URGENT_TH);
    localparam logic [OWE_W-1:0]   c_max_o = OWE_W'(MAX_OWE);

    ref_state_e        r_state;
    logic              r_refreq;
    logic              r_urgent;
    logic [OWE_W-1:0]  r_owed;
    logic              r_ovf;

    logic              w_due;
    logic              w_dec;
    logic [SUM_W-1:0]  w_sum_up;
    logic [SUM_W-1:0]  w_raw;
    logic              w_over;
    logic [OWE_W-1:0]  w_owed_next;

    ref_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick (
        .clk     (clk),
        .resetl  (resetl),
        .refrate (refrate),
        .tcount  (tcount),
        .due     (w_due)
    );

    assign w_dec       = (r_state == ST_BUSY) & refback & (w_sum_up != '0);
    assign w_sum_up    = SUM_W'(r_owed) + SUM_W'(w_due) + SUM_W'(startref);
    assign w_raw       = w_sum_up - SUM_W'(w_dec);
    assign w_over      = (w_raw > c_max);
    assign w_owed_next = w_over ? c_max_o : w_raw[OWE_W-1:0];

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_owed   <= '0;
            r_ovf    <= 1'b0;
            r_urgent <= 1'b0;
        end else begin
            r_owed   <= w_owed_next;
            r_urgent <= (SUM_W'(w_owed_next) >= c_urg);
            if (w_over) begin
                r_ovf <= 1'b1;
            end else if (ovfclr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_state  <= ST_IDLE;
            r_refreq <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_owed != '0) begin
                        r_state  <= ST_REQ;
                        r_refreq <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        r_state  <= ST_BUSY;
                        r_refreq <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (refback) begin
                        if (w_owed_next != '0) begin
                            r_state  <= ST_REQ;
                            r_refreq <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_refreq <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_refreq <= 1'b0;
                end
            endcase
        end
    end

    assign refreq = r_refreq;
    assign urgent = r_urgent;
    assign owed   = r_owed;
    assign ovf    = r_ovf;

endmodule : refresh_sched

`default_nettype wire
